i2c_master_scl_gen: RTL and testbench
=====================================

Name: i2c_master_scl_gen

Overview:
- SCL timing generator for the I2C master.
- Divides clk into four equal-length segments per bit:
  - seg0/seg1: SCL low.
  - seg2/seg3: SCL released high.
- Emits one-cycle segment strobes: ne, wbit, pe, rbit.
  - pe and rbit feed the clock-stretch detector directly downstream.
  - All four strobes drive the byte/bit datapath.
- Consumes the detector's stretch flag: seg2 is frozen while a slave holds SCL low.
- Owns the SCL open-drain enable and the synchronised SCL sample used by the whole master.

Parameters:
- CLK_DIV, 125: clk cycles per segment. Default gives 100 kHz at 50 MHz. Legal range ≥4, because stretch lags pe by 2 cycles.
- CNT_W, $clog2(CLK_DIV): segment counter width. Derived; never overridden.

Ports:
- clk  in  1  main clock.
- reset  in  1  synchronous, active-high.
- en  in  1  run request from the bit/byte controller; level-sensitive.
- stretch  in  1  from the clock-stretch detector; 1 = slave holding SCL low.
- scl_in  in  1  raw SCL pad input, asynchronous.
- scl_oe  out  1  1 = drive SCL low; 0 = release.
- scl_s  out  1  scl_in after 2-FF synchroniser; goes to the stretch detector.
- seg  out  2  current segment, 0..3.
- ne  out  1  strobe, first cycle of seg0 (SCL falling edge).
- wbit  out  1  strobe, first cycle of seg1 (SDA update point).
- pe  out  1  strobe, first cycle of seg2 (SCL rising edge).
- rbit  out  1  strobe, first cycle of seg3 (SDA sample point).
- bit_done  out  1  strobe, last cycle of seg3.
- busy  out  1  1 while in RUN.

Behaviour:
- Reset values: scl_oe=0, seg=0, all strobes 0, busy=0, counter 0, FSM=IDLE. Synchroniser flops reset to 1, so scl_s=1.
- All outputs are registered. Each strobe is high exactly on the first clk cycle on which seg shows the new value; bit_done is the exception and follows its own rule below.
- FSM IDLE:
  - scl_oe=0, busy=0, no strobes.
  - en=1 sampled → next cycle RUN, seg=0, cnt=0, ne=1, scl_oe=1.
- FSM RUN:
  - cnt increments each cycle. At cnt==CLK_DIV-1 it wraps to 0 and seg advances.
  - scl_oe=1 in seg0/seg1, 0 in seg2/seg3.
- Stretch freeze:
  - In seg2, any cycle with stretch=1 holds cnt and seg unchanged.
  - stretch is ignored in seg0, seg1 and seg3.
  - seg2 length = CLK_DIV + number of cycles stretch was high during seg2.
  - The first 2 cycles of seg2 may advance before stretch can assert (detector latency). This is accepted.
- Strobe exclusivity: pe is never reasserted during a freeze, and rbit is never issued while stretch=1.
- bit_done:
  - Asserted when seg==3 and cnt==CLK_DIV-1.
  - Next cycle: if en=1 → seg0 with ne (back-to-back bits, no gap). If en=0 → IDLE, scl_oe=0.
- en dropped mid-bit: the current bit completes through seg3, then IDLE. en is sampled only on the bit_done cycle.
- Reset mid-bit: next cycle IDLE, SCL released immediately. Partial bits are not completed.
- scl_s latency: 2 clk cycles from scl_in.

Decomposition:
- Shared package/include i2c_master_pkg:
  - Segment encodings SEG_LOW_A=0, SEG_LOW_B=1, SEG_HIGH_A=2, SEG_HIGH_B=3.
  - FSM state encodings IDLE/RUN.
  - Default CLK_DIV.
- Sub-module i2c_sync_2ff (two flops, reset value 1) for scl_in → scl_s. It is reused for SDA elsewhere.

Test Plan (CLK_DIV=4, nominal bit period 16 cycles):
1. Reset, then en=1 at cycle 0:
   - ne @1, wbit @5, pe @9, rbit @13, bit_done @16, ne @17.
   - scl_oe=1 @1–8, 0 @9–16.
2. Stretch in seg2: stretch=1 for 10 cycles starting at cnt==2 of seg2:
   - rbit delayed 10 cycles (@23); bit period 26.
   - Exactly one pe and one rbit.
   - No strobe fires during the freeze.
3. Stretch outside seg2: stretch=1 throughout seg0, seg1 and seg3 → timing identical to scenario 1.
4. en dropped mid-bit: en=0 at cycle 6 (seg1):
   - Bit completes with bit_done @16.
   - IDLE @17: scl_oe=0, busy=0, no ne.
5. Reset mid-bit: reset pulsed in seg1, cycle 6:
   - Cycle 7: scl_oe=0, seg=0, busy=0, no strobes.
   - en still 1 → ne the cycle after reset deasserts.
6. Synchroniser: scl_in toggled → scl_s follows exactly 2 cycles later; scl_s=1 after reset.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: segment and FSM encodings shared across the I2C master.
package i2c_master_pkg;
    localparam int CLK_DIV_DEFAULT = 125;
    typedef enum logic [1:0] {
        SEG_LOW_A  = 2'd0,
        SEG_LOW_B  = 2'd1,
        SEG_HIGH_A = 2'd2,
        SEG_HIGH_B = 2'd3
    } seg_e;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/i2c_sync_2ff.sv
// i2c_sync_2ff: two-flop synchroniser for open-drain pads; resets to the released (high) level.
module i2c_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], d};
    end
    assign q = sync_q[1];
endmodule

// File: rtl/i2c_master_scl_gen.sv
// i2c_master_scl_gen: four-segment SCL timing generator with stretch freeze in seg2.
module i2c_master_scl_gen
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       stretch,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       scl_s,
    output logic [1:0] seg,
    output logic       ne,
    output logic       wbit,
    output logic       pe,
    output logic       rbit,
    output logic       bit_done,
    output logic       busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    state_e           state_q, state_d;
    seg_e             seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic             ne_q, ne_d, wbit_q, wbit_d, pe_q, pe_d, rbit_q, rbit_d;
    logic             wrap, freeze, new_seg;
    i2c_sync_2ff u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .d     (scl_in),
        .q     (scl_s)
    );
    always_comb begin
        wrap    = cnt_q == CNT_MAX;
        freeze  = seg_q == SEG_HIGH_A && stretch;
        state_d = state_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (en) begin
                state_d = RUN;
                seg_d   = SEG_LOW_A;
                cnt_d   = '0;
            end
        end else if (!freeze) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                seg_d   = seg_q == SEG_HIGH_B ? SEG_LOW_A : seg_e'(seg_q + 2'd1);
                state_d = (seg_q == SEG_HIGH_B && !en) ? IDLE : RUN;
            end
        end
        // A segment is entered on leaving IDLE or on an unfrozen counter wrap that keeps us running.
        new_seg = state_d == RUN && (state_q == IDLE || (!freeze && wrap));
        ne_d    = new_seg && seg_d == SEG_LOW_A;
        wbit_d  = new_seg && seg_d == SEG_LOW_B;
        pe_d    = new_seg && seg_d == SEG_HIGH_A;
        rbit_d  = new_seg && seg_d == SEG_HIGH_B;
        done_d  = state_d == RUN && seg_d == SEG_HIGH_B && cnt_d == CNT_MAX;
        oe_d    = state_d == RUN && !seg_d[1];
        busy_d  = state_d == RUN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seg_q   <= SEG_LOW_A;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ne_q    <= 1'b0;
            wbit_q  <= 1'b0;
            pe_q    <= 1'b0;
            rbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ne_q    <= ne_d;
            wbit_q  <= wbit_d;
            pe_q    <= pe_d;
            rbit_q  <= rbit_d;
        end
    end
    assign scl_oe   = oe_q;
    assign seg      = seg_q;
    assign ne       = ne_q;
    assign wbit     = wbit_q;
    assign pe       = pe_q;
    assign rbit     = rbit_q;
    assign bit_done = done_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_master_scl_gen.sv
// tb_i2c_master_scl_gen: directed vector bench for the SCL generator at CLK_DIV=4.
module tb_i2c_master_scl_gen;
    logic       clk = 1'b0, reset = 1'b1, en = 1'b0, stretch = 1'b0, scl_in = 1'b1;
    logic       scl_oe, scl_s, ne, wbit, pe, rbit, bit_done, busy;
    logic [1:0] seg;
    int         checks = 0, errors = 0, cyc = 0;
    typedef struct {
        logic [1:0] seg;
        logic       oe;
        logic [4:0] strb;
    } vec_t;
    vec_t tbl[17];
    i2c_master_scl_gen #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .stretch  (stretch),
        .scl_in   (scl_in),
        .scl_oe   (scl_oe),
        .scl_s    (scl_s),
        .seg      (seg),
        .ne       (ne),
        .wbit     (wbit),
        .pe       (pe),
        .rbit     (rbit),
        .bit_done (bit_done),
        .busy     (busy)
    );
    always #5 clk = ~clk;
    function automatic logic [8:0] obs();
        return {seg, scl_oe, ne, wbit, pe, rbit, bit_done, busy};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic do_reset();
        reset   = 1'b1;
        en      = 1'b0;
        stretch = 1'b0;
        scl_in  = 1'b1;
        step();
        step();
        chk("reset_state", 32'({obs(), scl_s}), 32'b0000000001);
        reset = 1'b0;
        cyc   = 0;
    endtask
    // mode 0: nominal, 1: stretch held outside seg2, 2: en dropped at cycle 6
    task automatic run_table(input int mode);
        logic [8:0] exp;
        en      = 1'b1;
        stretch = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            exp = (mode == 2 && i == 16) ? 9'b0 : {tbl[i].seg, tbl[i].oe, tbl[i].strb, 1'b1};
            chk($sformatf("m%0d_c%0d", mode, cyc), 32'(obs()), 32'(exp));
            en      = !(mode == 2 && cyc >= 6);
            stretch = mode == 1 && tbl[i].seg != 2'd2;
        end
    endtask
    initial begin
        int n_pe, n_rbit, rbit_at, done_at, ne_at, frz_strb;
        for (int i = 0; i < 16; i++) begin
            tbl[i].seg  = 2'(i / 4);
            tbl[i].oe   = i < 8;
            tbl[i].strb = 5'b0;
        end
        tbl[16]      = '{2'd0, 1'b1, 5'b10000};
        tbl[0].strb  = 5'b10000;
        tbl[4].strb  = 5'b01000;
        tbl[8].strb  = 5'b00100;
        tbl[12].strb = 5'b00010;
        tbl[15].strb = 5'b00001;
        do_reset();
        run_table(0);
        do_reset();
        run_table(1);
        do_reset();
        run_table(2);
        step();
        chk("en_drop_stay_idle", 32'(obs()), 32'd0);
        do_reset();
        en = 1'b1;
        n_pe = 0; n_rbit = 0; rbit_at = 0; done_at = 0; ne_at = 0; frz_strb = 0;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (pe) n_pe++;
            if (rbit) begin n_rbit++; rbit_at = cyc; end
            if (bit_done) done_at = cyc;
            if (ne && cyc > 1) ne_at = cyc;
            if (cyc >= 12 && cyc <= 22 && (ne || wbit || pe || rbit || bit_done)) frz_strb++;
            if (cyc == 21) chk("stretch_seg_c21", 32'({seg, scl_oe}), 32'b100);
            stretch = cyc >= 11 && cyc <= 20;
        end
        chk("stretch_pe_count", n_pe, 1);
        chk("stretch_rbit_count", n_rbit, 1);
        chk("stretch_rbit_at", rbit_at, 23);
        chk("stretch_done_at", done_at, 26);
        chk("stretch_next_ne_at", ne_at, 27);
        chk("stretch_no_strobe_in_freeze", frz_strb, 0);
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 6; c++) step();
        chk("rst_mid_pre", 32'(obs()), 32'({2'd1, 1'b1, 5'b0, 1'b1}));
        reset = 1'b1;
        step();
        chk("rst_mid_c7", 32'(obs()), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_mid_c8_ne", 32'(obs()), 32'({2'd0, 1'b1, 5'b10000, 1'b1}));
        do_reset();
        scl_in = 1'b0;
        step();
        chk("sync_fall_p1", 32'(scl_s), 32'd1);
        step();
        chk("sync_fall_p2", 32'(scl_s), 32'd0);
        scl_in = 1'b1;
        step();
        chk("sync_rise_p1", 32'(scl_s), 32'd0);
        step();
        chk("sync_rise_p2", 32'(scl_s), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
